// File: rtl/tens_digit_scan.sv
// Tens-digit stage after a free-running units counter: counts units wraps, chains a carry,
// and scans a 2-digit common-anode 7-segment display (tens:units).
module tens_digit_scan #(
    parameter int unsigned UNITS_MAX   = 15,
    parameter int unsigned TENS_MAX    = 9,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] units,
    output logic [3:0] tens,
    output logic       carry_out,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic          digit_sel;
    logic [3:0]    units_q;
    logic          primed;

    logic          wrap_c;
    logic          slot_end_c;
    logic [3:0]    digit_c;
    logic [6:0]    seg_c;
    logic [1:0]    an_c;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit
    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Only a unit step UNITS_MAX -> 0 counts; primed masks the first sample after reset
    always_comb begin
        wrap_c     = primed && (units_q == 4'(UNITS_MAX)) && (units == 4'd0);
        slot_end_c = (prescaler == PW'(REFRESH_DIV - 1));
    end

    // Next display pattern from the current slot and the registered digit values
    always_comb begin
        digit_c = digit_sel ? tens : units_q;
        seg_c   = hex7(digit_c);
        an_c    = digit_sel ? 2'b01 : 2'b10;
        if (digit_sel && BLANK_LZ && (tens == 4'd0)) begin
            an_c = 2'b11;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tens      <= 4'd0;
            carry_out <= 1'b0;
            seg       <= 7'h7F;
            an        <= 2'b11;
            prescaler <= '0;
            digit_sel <= 1'b0;
            units_q   <= 4'd0;
            primed    <= 1'b0;
        end else begin
            units_q   <= units;
            primed    <= 1'b1;
            carry_out <= 1'b0;
            if (wrap_c) begin
                if (tens == 4'(TENS_MAX)) begin
                    tens      <= 4'd0;
                    carry_out <= 1'b1;
                end else begin
                    tens <= tens + 4'd1;
                end
            end
            if (slot_end_c) begin
                prescaler <= '0;
                digit_sel <= ~digit_sel;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
            seg <= seg_c;
            an  <= an_c;
        end
    end

endmodule

// File: tb/tb_tens_digit_scan.sv
// Directed-vector bench for tens_digit_scan with a 4-cycle refresh slot.
module tb_tens_digit_scan;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic [3:0] units = 4'd0;
    logic [3:0] tens;
    logic       carry_out;
    logic [6:0] seg;
    logic [1:0] an;

    int n_vec = 0;
    int n_bad = 0;

    tens_digit_scan #(
        .UNITS_MAX  (15),
        .TENS_MAX   (9),
        .REFRESH_DIV(4),
        .BLANK_LZ   (1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .units    (units),
        .tens     (tens),
        .carry_out(carry_out),
        .seg      (seg),
        .an       (an)
    );

    always #1 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic [3:0] u;
        logic [3:0] tens;
        logic       carry;
        logic [6:0] seg;
        logic [1:0] an;
    } vec_t;

    vec_t       tbl [24];
    logic [6:0] hex_tbl [16];

    task automatic step(input logic r, input logic [3:0] u);
        RST   = r;
        units = u;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        logic [3:0] tens_m;
        logic [3:0] uq_m;
        logic [3:0] u;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_carry;
        logic       ds;
        int         pulses;
        int         found;

        hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // reset hold, first scan slots, blanked tens slot, first wrap, tens=1 slot
        tbl[0]  = '{1'b1, 4'd0,  4'd0, 1'b0, 7'h7F, 2'b11};
        tbl[1]  = '{1'b1, 4'd0,  4'd0, 1'b0, 7'h7F, 2'b11};
        tbl[2]  = '{1'b1, 4'd0,  4'd0, 1'b0, 7'h7F, 2'b11};
        tbl[3]  = '{1'b0, 4'd0,  4'd0, 1'b0, 7'h40, 2'b10};
        tbl[4]  = '{1'b0, 4'd1,  4'd0, 1'b0, 7'h40, 2'b10};
        tbl[5]  = '{1'b0, 4'd2,  4'd0, 1'b0, 7'h79, 2'b10};
        tbl[6]  = '{1'b0, 4'd3,  4'd0, 1'b0, 7'h24, 2'b10};
        tbl[7]  = '{1'b0, 4'd4,  4'd0, 1'b0, 7'h40, 2'b11};
        tbl[8]  = '{1'b0, 4'd5,  4'd0, 1'b0, 7'h40, 2'b11};
        tbl[9]  = '{1'b0, 4'd6,  4'd0, 1'b0, 7'h40, 2'b11};
        tbl[10] = '{1'b0, 4'd7,  4'd0, 1'b0, 7'h40, 2'b11};
        tbl[11] = '{1'b0, 4'd8,  4'd0, 1'b0, 7'h78, 2'b10};
        tbl[12] = '{1'b0, 4'd9,  4'd0, 1'b0, 7'h00, 2'b10};
        tbl[13] = '{1'b0, 4'd10, 4'd0, 1'b0, 7'h10, 2'b10};
        tbl[14] = '{1'b0, 4'd11, 4'd0, 1'b0, 7'h08, 2'b10};
        tbl[15] = '{1'b0, 4'd12, 4'd0, 1'b0, 7'h40, 2'b11};
        tbl[16] = '{1'b0, 4'd13, 4'd0, 1'b0, 7'h40, 2'b11};
        tbl[17] = '{1'b0, 4'd14, 4'd0, 1'b0, 7'h40, 2'b11};
        tbl[18] = '{1'b0, 4'd15, 4'd0, 1'b0, 7'h40, 2'b11};
        tbl[19] = '{1'b0, 4'd0,  4'd1, 1'b0, 7'h0E, 2'b10};
        tbl[20] = '{1'b0, 4'd1,  4'd1, 1'b0, 7'h40, 2'b10};
        tbl[21] = '{1'b0, 4'd2,  4'd1, 1'b0, 7'h79, 2'b10};
        tbl[22] = '{1'b0, 4'd3,  4'd1, 1'b0, 7'h24, 2'b10};
        tbl[23] = '{1'b0, 4'd4,  4'd1, 1'b0, 7'h79, 2'b01};

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rst, tbl[i].u);
            chk($sformatf("tbl%0d_tens", i),  8'(tens),      8'(tbl[i].tens));
            chk($sformatf("tbl%0d_carry", i), 8'(carry_out), 8'(tbl[i].carry));
            chk($sformatf("tbl%0d_seg", i),   8'(seg),       8'(tbl[i].seg));
            chk($sformatf("tbl%0d_an", i),    8'(an),        8'(tbl[i].an));
        end

        // 160 wraps from a fresh reset; expectations derived from the stimulus count
        step(1'b1, 4'd0);
        chk("run_rst_an", 8'(an), 8'(2'b11));
        tens_m = 4'd0;
        uq_m   = 4'd0;
        pulses = 0;
        for (int k = 1; k <= 16 * 160 + 1; k++) begin
            u  = 4'((k - 1) % 16);
            ds = 1'(((k - 1) / 4) % 2);
            if (ds) begin
                exp_an  = (tens_m == 4'd0) ? 2'b11 : 2'b01;
                exp_seg = hex_tbl[tens_m];
            end else begin
                exp_an  = 2'b10;
                exp_seg = hex_tbl[uq_m];
            end
            exp_carry = 1'b0;
            if (k > 1 && u == 4'd0) begin
                tens_m    = (tens_m == 4'd9) ? 4'd0 : tens_m + 4'd1;
                exp_carry = (tens_m == 4'd0);
            end
            step(1'b0, u);
            chk("run_tens",  8'(tens),      8'(tens_m));
            chk("run_carry", 8'(carry_out), 8'(exp_carry));
            chk("run_an",    8'(an),        8'(exp_an));
            chk("run_seg",   8'(seg),       8'(exp_seg));
            if (ds && exp_an == 2'b01 && exp_seg == hex_tbl[3]) begin
                chk("tens3_seg", 8'(seg), 8'h30);
            end
            if (carry_out === 1'b1) pulses++;
            uq_m = u;
        end
        chk("carry_pulses", 8'(pulses), 8'd16);

        // non-unit jumps must not count
        step(1'b0, 4'd7);
        step(1'b0, 4'd0);
        chk("jump7_0_tens",  8'(tens),      8'd0);
        chk("jump7_0_carry", 8'(carry_out), 8'd0);
        step(1'b0, 4'd15);
        step(1'b0, 4'd3);
        chk("jump15_3_tens",  8'(tens),      8'd0);
        chk("jump15_3_carry", 8'(carry_out), 8'd0);
        step(1'b0, 4'd15);
        step(1'b0, 4'd0);
        chk("real_wrap_tens", 8'(tens), 8'd1);

        for (int w = 0; w < 4; w++) begin
            for (int v = 1; v < 16; v++) step(1'b0, 4'(v));
            step(1'b0, 4'd0);
        end
        chk("tens5", 8'(tens), 8'd5);
        chk("tens5_carry", 8'(carry_out), 8'd0);

        // mid-scan reset while the tens slot is lit
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step(1'b0, 4'd5);
            if (an == 2'b01) found = 1;
        end
        chk("find_tens_slot", 8'(found), 8'd1);
        step(1'b1, 4'd5);
        chk("midrst_tens",  8'(tens),      8'd0);
        chk("midrst_carry", 8'(carry_out), 8'd0);
        chk("midrst_an",    8'(an),        8'(2'b11));
        chk("midrst_seg",   8'(seg),       8'h7F);
        step(1'b0, 4'd5);
        chk("postrst_an",   8'(an),        8'(2'b10));
        chk("postrst_seg",  8'(seg),       8'h40);
        chk("postrst_tens", 8'(tens),      8'd0);
        step(1'b0, 4'd5);
        chk("postrst2_seg", 8'(seg),       8'h12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
